// File: rtl/wishbone_arbiter.sv
// N-to-1 Wishbone classic round-robin arbiter, one non-pipelined transaction at a time.
// Optional bus-timeout error path enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter #(
  parameter int NUM_CTRL       = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_W         = DATA_W / 8,
  localparam int GW            = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CTRL-1:0]        c_cyc,
  input  logic [NUM_CTRL-1:0]        c_stb,
  input  logic [NUM_CTRL-1:0]        c_we,
  input  logic [NUM_CTRL*SEL_W-1:0]  c_sel,
  input  logic [NUM_CTRL*ADDR_W-1:0] c_addr,
  input  logic [NUM_CTRL*DATA_W-1:0] c_data_wr,
  output logic [NUM_CTRL-1:0]        c_ack,
  output logic [NUM_CTRL-1:0]        c_err,
  output logic [DATA_W-1:0]          c_data_rd,
  output logic                       p_cyc,
  output logic                       p_stb,
  output logic                       p_we,
  output logic [SEL_W-1:0]           p_sel,
  output logic [ADDR_W-1:0]          p_addr,
  output logic [DATA_W-1:0]          p_data_wr,
  input  logic                       p_ack,
  input  logic                       p_err,
  input  logic [DATA_W-1:0]          p_data_rd,
  output logic                       busy,
  output logic [GW-1:0]              grant_idx,
  output logic                       timeout
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_TERR = 2'd2} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1} state_t;
`endif

  state_t              state_r;
  state_t              state_n_s;
  logic [GW-1:0]       grant_idx_r;
  logic [GW-1:0]       next_grant_s;
  logic                req_any_s;
  logic [NUM_CTRL-1:0] req_s;
  logic                timeout_hit_s;

  logic                gnt_cyc_s;
  logic                gnt_stb_s;
  logic                gnt_we_s;
  logic [SEL_W-1:0]    gnt_sel_s;
  logic [ADDR_W-1:0]   gnt_addr_s;
  logic [DATA_W-1:0]   gnt_data_s;

  // Controller index 'off' positions after 'base', wrapping at NUM_CTRL.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM_CTRL;
    return sum[GW-1:0];
  endfunction

  assign req_s = c_cyc & c_stb;

  // Round-robin search: the smallest offset from the last grant wins.
  always_comb begin
    req_any_s    = 1'b0;
    next_grant_s = grant_idx_r;
    for (int off = NUM_CTRL; off >= 1; off--) begin
      if (req_s[rr_idx(grant_idx_r, off)]) begin
        req_any_s    = 1'b1;
        next_grant_s = rr_idx(grant_idx_r, off);
      end else begin
        req_any_s    = req_any_s;
      end
    end
  end

  // Select the granted controller's request signals.
  always_comb begin
    gnt_cyc_s  = 1'b0;
    gnt_stb_s  = 1'b0;
    gnt_we_s   = 1'b0;
    gnt_sel_s  = {SEL_W{1'b0}};
    gnt_addr_s = {ADDR_W{1'b0}};
    gnt_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CTRL; i++) begin
      gnt_cyc_s  = gnt_cyc_s  | (c_cyc[i] & (grant_idx_r == GW'(i)));
      gnt_stb_s  = gnt_stb_s  | (c_stb[i] & (grant_idx_r == GW'(i)));
      gnt_we_s   = gnt_we_s   | (c_we[i]  & (grant_idx_r == GW'(i)));
      gnt_sel_s  = gnt_sel_s  | (c_sel[i*SEL_W +: SEL_W]      & {SEL_W{grant_idx_r == GW'(i)}});
      gnt_addr_s = gnt_addr_s | (c_addr[i*ADDR_W +: ADDR_W]   & {ADDR_W{grant_idx_r == GW'(i)}});
      gnt_data_s = gnt_data_s | (c_data_wr[i*DATA_W +: DATA_W] & {DATA_W{grant_idx_r == GW'(i)}});
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  // Busy-cycle counter: cleared on grant, saturating while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_BUSY && cnt_r != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The T-th busy cycle without a response is the last one.
  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout       = (state_r == ST_TERR);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
  assign timeout_hit_s    = 1'b0;
  assign timeout          = 1'b0;
`endif

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      grant_idx_r <= GW'(NUM_CTRL - 1);
    end else begin
      state_r <= state_n_s;
      if (state_r == ST_IDLE && req_any_s) begin
        grant_idx_r <= next_grant_s;
      end else begin
        grant_idx_r <= grant_idx_r;
      end
    end
  end

  // Next-state logic; a response beats a simultaneous abort or timeout.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) state_n_s = ST_BUSY;
        else           state_n_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (p_ack || p_err)     state_n_s = ST_IDLE;
        else if (!gnt_cyc_s)    state_n_s = ST_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit_s) state_n_s = ST_TERR;
`endif
        else                    state_n_s = ST_BUSY;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_TERR: state_n_s = ST_IDLE;
`endif
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Peripheral request and controller response routing.
  always_comb begin
    p_cyc     = 1'b0;
    p_stb     = 1'b0;
    p_we      = 1'b0;
    p_sel     = {SEL_W{1'b0}};
    p_addr    = {ADDR_W{1'b0}};
    p_data_wr = {DATA_W{1'b0}};
    c_ack     = {NUM_CTRL{1'b0}};
    c_err     = {NUM_CTRL{1'b0}};
    case (state_r)
      ST_BUSY: begin
        p_cyc     = gnt_cyc_s;
        p_stb     = gnt_stb_s;
        p_we      = gnt_we_s;
        p_sel     = gnt_sel_s;
        p_addr    = gnt_addr_s;
        p_data_wr = gnt_data_s;
        for (int i = 0; i < NUM_CTRL; i++) begin
          // An aborting controller gets no termination.
          c_ack[i] = (grant_idx_r == GW'(i)) & p_ack & gnt_cyc_s;
          c_err[i] = (grant_idx_r == GW'(i)) & p_err & gnt_cyc_s;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_TERR: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          c_err[i] = (grant_idx_r == GW'(i));
        end
      end
`endif
      default: begin
        p_cyc = 1'b0;
      end
    endcase
  end

  assign c_data_rd = p_data_rd;
  assign busy      = (state_r == ST_BUSY);
  assign grant_idx = grant_idx_r;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized bench for wishbone_arbiter against a transaction-level reference model.
module tb_wishbone_arbiter;
  localparam int NC   = 3;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int T    = 6;
  localparam int GW   = 2;
  localparam int SELB = NC * SW;
  localparam int ADRB = NC * AW;
  localparam int DATB = NC * DW;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NC-1:0]   c_cyc, c_stb, c_we;
  logic [SELB-1:0] c_sel;
  logic [ADRB-1:0] c_addr;
  logic [DATB-1:0] c_data_wr;
  logic [NC-1:0]   c_ack, c_err;
  logic [DW-1:0]   c_data_rd;
  logic            p_cyc, p_stb, p_we;
  logic [SW-1:0]   p_sel;
  logic [AW-1:0]   p_addr;
  logic [DW-1:0]   p_data_wr;
  logic            p_ack, p_err;
  logic [DW-1:0]   p_data_rd;
  logic            busy;
  logic [GW-1:0]   grant_idx;
  logic            timeout;

  wishbone_arbiter #(.NUM_CTRL(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we), .c_sel(c_sel), .c_addr(c_addr),
    .c_data_wr(c_data_wr), .c_ack(c_ack), .c_err(c_err), .c_data_rd(c_data_rd),
    .p_cyc(p_cyc), .p_stb(p_stb), .p_we(p_we), .p_sel(p_sel), .p_addr(p_addr),
    .p_data_wr(p_data_wr), .p_ack(p_ack), .p_err(p_err), .p_data_rd(p_data_rd),
    .busy(busy), .grant_idx(grant_idx), .timeout(timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns the bus, whether a timeout error is pending,
  // the last granted controller and how many unanswered busy cycles elapsed.
  int m_owner;
  int m_last;
  int m_age;
  bit m_terr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_last  = NC - 1;
    m_age   = 0;
    m_terr  = 1'b0;
  endtask

  task automatic drive_random(input int cyc_pct, input int ack_pct, input int err_pct, input int rst_pct);
    for (int i = 0; i < NC; i++) begin
      c_cyc[i] = ($urandom_range(99) < cyc_pct);
      c_stb[i] = c_cyc[i] ? ($urandom_range(99) < cyc_pct) : 1'($urandom_range(1));
      c_we[i]  = 1'($urandom_range(1));
    end
    c_sel     = SELB'($urandom);
    c_addr    = ADRB'({$urandom, $urandom});
    c_data_wr = DATB'({$urandom, $urandom, $urandom});
    p_ack     = ($urandom_range(99) < ack_pct);
    p_err     = ($urandom_range(99) < err_pct);
    p_data_rd = $urandom;
    rst       = ($urandom_range(99) < rst_pct);
  endtask

  // Check one cycle's outputs against the model, then advance the model across the edge.
  task automatic run_cycle();
    logic          e_cyc, e_stb, e_we, e_busy, e_to;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [NC-1:0] e_ack, e_err;
    int            o;
    #3;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_to = 1'b0;
    e_sel = '0; e_addr = '0; e_wd = '0; e_ack = '0; e_err = '0;
    o = m_owner;
    if (m_terr) begin
      e_err[m_last] = 1'b1;
      e_to          = 1'b1;
    end else if (o >= 0) begin
      e_busy = 1'b1;
      e_cyc  = c_cyc[o];
      e_stb  = c_stb[o];
      e_we   = c_we[o];
      e_sel  = c_sel[o*SW +: SW];
      e_addr = c_addr[o*AW +: AW];
      e_wd   = c_data_wr[o*DW +: DW];
      if (c_cyc[o]) begin
        e_ack[o] = p_ack;
        e_err[o] = p_err;
      end
    end
    check_eq("p_cyc", 64'(p_cyc), 64'(e_cyc));
    check_eq("p_stb", 64'(p_stb), 64'(e_stb));
    check_eq("p_we", 64'(p_we), 64'(e_we));
    check_eq("p_sel", 64'(p_sel), 64'(e_sel));
    check_eq("p_addr", 64'(p_addr), 64'(e_addr));
    check_eq("p_data_wr", 64'(p_data_wr), 64'(e_wd));
    check_eq("c_ack", 64'(c_ack), 64'(e_ack));
    check_eq("c_err", 64'(c_err), 64'(e_err));
    check_eq("c_data_rd", 64'(c_data_rd), 64'(p_data_rd));
    check_eq("busy", 64'(busy), 64'(e_busy));
    check_eq("timeout", 64'(timeout), 64'(e_to));
    check_eq("grant_idx", 64'(grant_idx), 64'(m_last));

    if (rst) begin
      m_reset();
    end else if (m_terr) begin
      m_terr = 1'b0;
    end else if (o >= 0) begin
      if (p_ack || p_err || !c_cyc[o]) begin
        m_owner = -1;
      end else begin
        m_age++;
        if (TO_EN && m_age >= T) begin
          m_terr  = 1'b1;
          m_owner = -1;
        end
      end
    end else begin
      for (int k = 1; k <= NC; k++) begin
        int j;
        j = (m_last + k) % NC;
        if (m_owner < 0 && c_cyc[j] && c_stb[j]) begin
          m_owner = j;
          m_last  = j;
          m_age   = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  int ph_len[5]  = '{60, 400, 1000, 400, 100};
  int ph_cyc[5]  = '{100, 85, 100, 95, 90};
  int ph_ack[5]  = '{100, 30, 0, 15, 40};
  int ph_err[5]  = '{0, 10, 0, 5, 10};
  int ph_rst[5]  = '{0, 2, 0, 1, 5};

  initial begin
    rst = 1'b1;
    c_cyc = '0; c_stb = '0; c_we = '0; c_sel = '0; c_addr = '0; c_data_wr = '0;
    p_ack = 1'b0; p_err = 1'b0; p_data_rd = '0;
    @(posedge clk);
    #1;
    m_reset();
    run_cycle();
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        drive_random(ph_cyc[p], ph_ack[p], ph_err[p], ph_rst[p]);
        run_cycle();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
